uart_cmd_parser: RTL and testbench

//  Downstream of the UART receiver (top_uart rx_out/rx_done_tick): assembles 4-byte command

---
 rtl/robozap_uart_pkg.sv | 19 +
 rtl/uart_gap_timer.sv | 30 +++
 rtl/uart_cmd_parser.sv | 112 +++++++++++
 tb/tb_uart_cmd_parser.sv | 246 ++++++++++++++++++++++++
 4 files changed

// File: rtl/robozap_uart_pkg.sv
// Shared types and constants for the RoboZap UART command path.
// Frame on the wire: SYNC, CMD, ARG, CHK with CHK = CMD ^ ARG ^ CHK_SALT.
package robozap_uart_pkg;

   typedef enum logic [1:0] {S_SYNC, S_CMD, S_ARG, S_CHK} parser_state_t;

   localparam logic [7:0] SYNC_DEFAULT = 8'hA5;
   localparam logic [7:0] CHK_SALT     = 8'h5A;

   // Opcodes pass through the parser undecoded; listed here for the game logic.
   localparam logic [7:0] CMD_MOVE  = 8'h01;
   localparam logic [7:0] CMD_FIRE  = 8'h02;
   localparam logic [7:0] CMD_PAUSE = 8'h03;

   function automatic logic [7:0] frame_chk(input logic [7:0] op, input logic [7:0] arg);
      return op ^ arg ^ CHK_SALT;
   endfunction

endpackage

// File: rtl/uart_gap_timer.sv
// Inter-byte gap counter: expires after TICKS-1 cycles of running without a clear.
module uart_gap_timer #(
   parameter int unsigned TICKS = 200_000
) (
   input  logic clk,
   input  logic rst_n,
   input  logic clear,
   input  logic run,
   output logic expired
);

   localparam int unsigned CW = (TICKS > 1) ? $clog2(TICKS) : 1;
   localparam logic [CW-1:0] LAST = CW'(TICKS - 1);

   logic [CW-1:0] r_cnt;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_cnt <= '0;
      end else if (clear || !run || expired) begin
         r_cnt <= '0;
      end else begin
         r_cnt <= r_cnt + 1'b1;
      end
   end

   // A byte arriving in the terminal cycle wins over the timeout.
   assign expired = run && !clear && (r_cnt == LAST);

endmodule

// File: rtl/uart_cmd_parser.sv
// Assembles SYNC/CMD/ARG/CHK byte frames into validated commands with a one-entry
// output buffer, saturating error counter and sticky overflow flag.
module uart_cmd_parser
   import robozap_uart_pkg::*;
#(
   parameter int unsigned CLK_HZ     = 100_000_000,
   parameter int unsigned TIMEOUT_US = 2000,
   parameter logic [7:0]  SYNC_BYTE  = SYNC_DEFAULT
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic [7:0] rx_data,
   input  logic       rx_valid,
   input  logic       cmd_ready,
   output logic       cmd_valid,
   output logic [7:0] cmd_op,
   output logic [7:0] cmd_arg,
   output logic [7:0] err_cnt,
   output logic       err_pulse,
   output logic       overflow
);

   localparam int unsigned TICKS = CLK_HZ / 1_000_000 * TIMEOUT_US;

   parser_state_t r_state, w_state_d;
   logic [7:0]    r_op, r_arg;
   logic          r_cmd_valid, r_err_pulse, r_overflow;
   logic [7:0]    r_cmd_op, r_cmd_arg, r_err_cnt;
   logic          w_expired, w_good, w_chk_bad, w_bad, w_xfer;

   uart_gap_timer #(
      .TICKS (TICKS)
   ) u_gap_timer (
      .clk     (clk),
      .rst_n   (rst_n),
      .clear   (rx_valid),
      .run     (r_state != S_SYNC),
      .expired (w_expired)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= S_SYNC;
      end else begin
         r_state <= w_state_d;
      end
   end

   always_comb begin
      w_state_d = r_state;
      w_good    = 1'b0;
      w_chk_bad = 1'b0;
      if (rx_valid) begin
         case (r_state)
            S_SYNC: if (rx_data == SYNC_BYTE) w_state_d = S_CMD;
            S_CMD:  w_state_d = S_ARG;
            S_ARG:  w_state_d = S_CHK;
            S_CHK: begin
               w_state_d = S_SYNC;
               if (rx_data == frame_chk(r_op, r_arg)) w_good = 1'b1;
               else                                   w_chk_bad = 1'b1;
            end
         endcase
      end else if (w_expired) begin
         w_state_d = S_SYNC;
      end
   end

   assign w_bad  = w_chk_bad || w_expired;
   assign w_xfer = r_cmd_valid && cmd_ready;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_op  <= '0;
         r_arg <= '0;
      end else if (rx_valid) begin
         if (r_state == S_CMD) r_op  <= rx_data;
         if (r_state == S_ARG) r_arg <= rx_data;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_cmd_valid <= 1'b0;
         r_cmd_op    <= '0;
         r_cmd_arg   <= '0;
         r_overflow  <= 1'b0;
         r_err_pulse <= 1'b0;
         r_err_cnt   <= '0;
      end else begin
         r_err_pulse <= w_bad;
         if (w_bad && (r_err_cnt != 8'hFF)) r_err_cnt <= r_err_cnt + 8'd1;
         // A transfer in the same cycle frees the slot, so a good frame reloads without a bubble.
         if (w_good && (!r_cmd_valid || w_xfer)) begin
            r_cmd_valid <= 1'b1;
            r_cmd_op    <= r_op;
            r_cmd_arg   <= r_arg;
         end else begin
            if (w_good) r_overflow  <= 1'b1;
            if (w_xfer) r_cmd_valid <= 1'b0;
         end
      end
   end

   assign cmd_valid = r_cmd_valid;
   assign cmd_op    = r_cmd_op;
   assign cmd_arg   = r_cmd_arg;
   assign err_cnt   = r_err_cnt;
   assign err_pulse = r_err_pulse;
   assign overflow  = r_overflow;

endmodule

// File: tb/tb_uart_cmd_parser.sv
// Randomized and directed bench for uart_cmd_parser against a byte-level frame model.
module tb_uart_cmd_parser;

   localparam int TICKS = 100;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic [7:0] rx_data = '0;
   logic       rx_valid = 1'b0;
   logic       cmd_ready = 1'b0;
   logic       cmd_valid, err_pulse, overflow;
   logic [7:0] cmd_op, cmd_arg, err_cnt;

   always #5 clk = ~clk;

   uart_cmd_parser #(
      .CLK_HZ     (100_000_000),
      .TIMEOUT_US (1),
      .SYNC_BYTE  (8'hA5)
   ) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .rx_data   (rx_data),
      .rx_valid  (rx_valid),
      .cmd_ready (cmd_ready),
      .cmd_valid (cmd_valid),
      .cmd_op    (cmd_op),
      .cmd_arg   (cmd_arg),
      .err_cnt   (err_cnt),
      .err_pulse (err_pulse),
      .overflow  (overflow)
   );

   int n_checks = 0;
   int n_errors = 0;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Reference model: partial frame bytes, expected deliveries, error and overflow state.
   logic [7:0]  m_part[$];
   logic [15:0] exp_q[$];
   logic [15:0] got_q[$];
   logic [15:0] m_pend;
   bit          m_full, m_ovf;
   int          m_err, idle_since, pulse_cnt;

   always @(negedge clk) begin
      if (!rst_n) begin
         pulse_cnt = 0;
         got_q.delete();
      end else begin
         if (cmd_valid && cmd_ready) got_q.push_back({cmd_op, cmd_arg});
         if (err_pulse) pulse_cnt++;
      end
   end

   task automatic model_good(input logic [7:0] op, input logic [7:0] arg);
      if (cmd_ready) exp_q.push_back({op, arg});
      else if (!m_full) begin
         m_full = 1'b1;
         m_pend = {op, arg};
      end else m_ovf = 1'b1;
   endtask

   task automatic model_byte(input logic [7:0] b);
      if (m_part.size() == 0) begin
         if (b == 8'hA5) m_part.push_back(b);
      end else begin
         m_part.push_back(b);
         if (m_part.size() == 4) begin
            if (m_part[3] == (m_part[1] ^ m_part[2] ^ 8'h5A)) model_good(m_part[1], m_part[2]);
            else m_err++;
            m_part.delete();
         end
      end
   endtask

   task automatic idle(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
         idle_since++;
         if (m_part.size() != 0 && idle_since == TICKS) begin
            m_err++;
            m_part.delete();
         end
      end
   endtask

   task automatic send(input logic [7:0] b);
      rx_data  = b;
      rx_valid = 1'b1;
      @(posedge clk);
      #1;
      rx_valid   = 1'b0;
      idle_since = 0;
      model_byte(b);
   endtask

   task automatic frame(input logic [7:0] op, input logic [7:0] arg, input logic [7:0] chk);
      send(8'hA5); idle(2);
      send(op);    idle(2);
      send(arg);   idle(2);
      send(chk);   idle(2);
   endtask

   task automatic set_ready(input logic v);
      cmd_ready = v;
      if (v && m_full) begin
         exp_q.push_back(m_pend);
         m_full = 1'b0;
      end
   endtask

   task automatic do_reset(input string tag);
      rst_n = 1'b0;
      #1;
      check({tag, "/rst_valid"}, cmd_valid, 0);
      check({tag, "/rst_op"},    cmd_op, 0);
      check({tag, "/rst_arg"},   cmd_arg, 0);
      check({tag, "/rst_errcnt"}, err_cnt, 0);
      check({tag, "/rst_pulse"}, err_pulse, 0);
      check({tag, "/rst_ovf"},   overflow, 0);
      m_part.delete();
      exp_q.delete();
      m_full = 1'b0;
      m_ovf = 1'b0;
      m_err = 0;
      idle_since = 0;
      rx_valid = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      rst_n = 1'b1;
   endtask

   task automatic check_model(input string tag);
      int n;
      idle(3);
      check({tag, "/xfers"}, got_q.size(), exp_q.size());
      n = (got_q.size() < exp_q.size()) ? got_q.size() : exp_q.size();
      for (int i = 0; i < n; i++) check({tag, "/cmd"}, got_q[i], exp_q[i]);
      check({tag, "/errcnt"}, err_cnt, (m_err > 255) ? 255 : m_err);
      check({tag, "/pulses"}, pulse_cnt, m_err);
      check({tag, "/ovf"}, overflow, m_ovf);
      check({tag, "/valid"}, cmd_valid, m_full);
      if (m_full) check({tag, "/held"}, {cmd_op, cmd_arg}, m_pend);
      got_q.delete();
      exp_q.delete();
   endtask

   initial begin
      logic [7:0] op, arg, b;
      int         kind;

      do_reset("t0");
      set_ready(1'b1);

      frame(8'h01, 8'h07, 8'h5C);
      check_model("t1");

      frame(8'h02, 8'h10, 8'h00);
      check_model("t2_bad");
      frame(8'h03, 8'hA5, 8'h03 ^ 8'hA5 ^ 8'h5A);
      check_model("t2_good");

      do_reset("t3");
      send(8'hA5); idle(2); send(8'h03);
      idle(TICKS + 2);
      send(8'h00); idle(2);
      frame(8'h01, 8'h07, 8'h5C);
      check_model("t3");

      // Gap of exactly TICKS cycles between strobes must not time out.
      send(8'hA5); idle(2); send(8'h01); idle(TICKS - 1);
      send(8'h07); idle(2); send(8'h5C); idle(2);
      check_model("t3_edge");

      do_reset("t4");
      send(8'hFF); idle(2); send(8'h00); idle(2);
      frame(8'h01, 8'h07, 8'h5C);
      check_model("t4");

      do_reset("t5");
      set_ready(1'b0);
      frame(8'h01, 8'h07, 8'h5C);
      frame(8'h02, 8'h03, 8'h5B);
      check_model("t5_full");
      set_ready(1'b1);
      check_model("t5_drain");

      send(8'hA5); idle(2); send(8'h01); idle(2);
      do_reset("t6");
      set_ready(1'b1);
      frame(8'h01, 8'h07, 8'h5C);
      check_model("t6");
      for (int i = 0; i < 256; i++) frame(8'h01, 8'h07, 8'h00);
      check_model("t6_sat");

      do_reset("rnd");
      set_ready(1'b1);
      for (int it = 0; it < 80; it++) begin
         kind = $urandom_range(0, 4);
         op   = 8'($urandom);
         arg  = ($urandom_range(0, 5) == 0) ? 8'hA5 : 8'($urandom);
         case (kind)
            0: frame(op, arg, op ^ arg ^ 8'h5A);
            1: frame(op, arg, op ^ arg ^ 8'h5A ^ 8'($urandom_range(1, 255)));
            2: begin
               repeat ($urandom_range(1, 3)) begin
                  b = 8'($urandom);
                  if (b == 8'hA5) b = 8'h00;
                  send(b); idle($urandom_range(1, 3));
               end
               frame(op, arg, op ^ arg ^ 8'h5A);
            end
            3: begin
               send(8'hA5);
               repeat ($urandom_range(0, 2)) begin
                  idle(1);
                  send(8'($urandom));
               end
               idle(TICKS + $urandom_range(0, 3));
            end
            default: begin
               send(8'hA5); idle(1); send(op);
               idle($urandom_range(TICKS - 3, TICKS + 3));
               send(arg); idle(1); send(op ^ arg ^ 8'h5A); idle(2);
            end
         endcase
         if (it % 10 == 9) begin
            idle(TICKS + 2);
            check_model("rnd");
         end
      end

      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end

endmodule
